// File: rtl/advanced_counter_pkg.sv
// Shared field indices, widths and next-value arithmetic for the advanced_counter core.
// Decodes the ui_in control fields and clamps or wraps the count at the 8-bit limits.
package advanced_counter_pkg;

  localparam int COUNT_W  = 8;
  localparam int CNT_EN   = 0;
  localparam int UP       = 1;
  localparam int LOAD     = 2;
  localparam int SAT      = 3;
  localparam int STEP_LSB = 4;
  localparam int STEP_MSB = 7;

  typedef logic [3:0] step_t;

  // Computed at 9 bits so bit 8 flags carry (up) or borrow (down) for saturation.
  function automatic logic [COUNT_W-1:0] next_count(
    input logic [COUNT_W-1:0] cur,
    input logic               up,
    input logic               sat,
    input step_t              step
  );
    logic [COUNT_W:0] wide;
    logic [COUNT_W-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {5'b0_0000, step};
      res  = (sat && wide[COUNT_W]) ? {COUNT_W{1'b1}} : wide[COUNT_W-1:0];
    end else begin
      wide = {1'b0, cur} - {5'b0_0000, step};
      res  = (sat && wide[COUNT_W]) ? {COUNT_W{1'b0}} : wide[COUNT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/advanced_counter_if.sv
// TinyTapeout-style pin bundle between the tile wrapper (master) and the counter core (slave).
// All signals are plain levels sampled on the core clock; there is no valid/ready handshake.
interface advanced_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/advanced_counter_prescaler.sv
// Free-running DIV_WIDTH-bit prescaler with synchronous clear; tick marks the all-ones phase.
module prescaler #(
  parameter int DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic adv,
  output logic tick
);
  logic [DIV_WIDTH-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr)      pre_d = '0;
    else if (adv) pre_d = pre_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    pre_q <= pre_d;
  end

  assign tick = &pre_q;
endmodule

// File: rtl/tt_um_advanced_counter.sv
// TinyTapeout tile wrapper: maps the standard pins onto the counter core, inverting rst_n.
module tt_um_advanced_counter #(
  parameter int DIV_WIDTH = 24
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  advanced_counter_if bus ();

  assign bus.ena    = ena;
  assign bus.ui_in  = ui_in;
  assign bus.uio_in = uio_in;
  assign uo_out     = bus.uo_out;
  assign uio_out    = bus.uio_out;
  assign uio_oe     = bus.uio_oe;

  advanced_counter #(.DIV_WIDTH(DIV_WIDTH)) u_core (
    .clk (clk),
    .rst (~rst_n),
    .bus (bus)
  );
endmodule

// File: rtl/advanced_counter.sv
// Programmable 8-bit up/down counter: prescaled ticks, 4-bit step, parallel load, wrap or saturate.
module advanced_counter
  import advanced_counter_pkg::*;
#(
  parameter int DIV_WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst,
  advanced_counter_if.slave   bus
);
  logic               tick;
  logic               load;
  logic               pre_clr;
  step_t              step;
  logic [COUNT_W-1:0] count_q, count_d;

  assign load    = bus.ui_in[LOAD];
  assign step    = bus.ui_in[STEP_MSB:STEP_LSB];
  // Load restarts the phase so the next update comes a full period after the last load edge.
  assign pre_clr = rst | (bus.ena & load);

  prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk  (clk),
    .clr  (pre_clr),
    .adv  (bus.ena),
    .tick (tick)
  );

  always_comb begin
    count_d = count_q;
    if (rst) begin
      count_d = '0;
    end else if (bus.ena) begin
      if (load)
        count_d = bus.uio_in;
      else if (tick && bus.ui_in[CNT_EN])
        count_d = next_count(count_q, bus.ui_in[UP], bus.ui_in[SAT], step);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign bus.uo_out  = count_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_advanced_counter.sv
// Bench for advanced_counter with DIV_WIDTH=2: directed scenarios plus random traffic
// checked against an integer-arithmetic model of the count rules.
module tb_advanced_counter;
  localparam int DIV_WIDTH = 2;
  localparam int PERIOD    = 1 << DIV_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  advanced_counter_if bus ();

  advanced_counter #(.DIV_WIDTH(DIV_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  // Model state: count as an integer and edges elapsed since the phase was last cleared.
  int m_count = 0;
  int m_phase = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] ctl(input bit en, input bit up, input bit ld,
                                     input bit sat, input int step);
    logic [3:0] s;
    s = step[3:0];
    return {s, sat, ld, up, en};
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [7:0] ui, input logic [7:0] uio);
    int s;
    if (r) begin
      m_count = 0;
      m_phase = 0;
    end else if (e) begin
      if (ui[2]) begin
        m_count = uio;
        m_phase = 0;
      end else begin
        if (m_phase == PERIOD - 1 && ui[0]) begin
          s = ui[7:4];
          if (ui[1]) m_count = ui[3] ? ((m_count + s > 255) ? 255 : m_count + s)
                                     : (m_count + s) % 256;
          else       m_count = ui[3] ? ((m_count - s < 0) ? 0 : m_count - s)
                                     : (m_count - s + 256) % 256;
        end
        m_phase = (m_phase + 1) % PERIOD;
      end
    end
    exp_q.push_back(m_count[7:0]);
  endtask

  task automatic cycle(input bit r, input bit e, input logic [7:0] ui, input logic [7:0] uio);
    @(negedge clk);
    rst        = r;
    bus.ena    = e;
    bus.ui_in  = ui;
    bus.uio_in = uio;
    @(posedge clk);
    model_edge(r, e, ui, uio);
    #1;
    check("count", bus.uo_out, exp_q.pop_front());
    check("uio_oe", bus.uio_oe, 8'h00);
    check("uio_out", bus.uio_out, 8'h00);
  endtask

  task automatic cycles(input int n, input bit e, input logic [7:0] ui);
    for (int i = 0; i < n; i++) cycle(1'b0, e, ui, 8'h00);
  endtask

  initial begin
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Reset and first increments.
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    check("reset_value", bus.uo_out, 8'h00);
    cycles(3, 1'b1, ctl(1, 1, 0, 0, 1));
    check("before_first_tick", bus.uo_out, 8'h00);
    cycles(1, 1'b1, ctl(1, 1, 0, 0, 1));
    check("first_tick", bus.uo_out, 8'h01);
    cycles(8, 1'b1, ctl(1, 1, 0, 0, 1));
    check("third_tick", bus.uo_out, 8'h03);

    // Load 0xFE and wrap upward.
    cycle(1'b0, 1'b1, ctl(1, 1, 1, 0, 1), 8'hFE);
    check("load_fe", bus.uo_out, 8'hFE);
    cycles(4, 1'b1, ctl(1, 1, 0, 0, 1));
    check("up_to_ff", bus.uo_out, 8'hFF);
    cycles(4, 1'b1, ctl(1, 1, 0, 0, 1));
    check("wrap_to_00", bus.uo_out, 8'h00);

    // Saturate upward with overshoot.
    cycle(1'b0, 1'b1, ctl(1, 1, 1, 1, 3), 8'hFE);
    cycles(4, 1'b1, ctl(1, 1, 0, 1, 3));
    check("sat_up_clamp", bus.uo_out, 8'hFF);
    cycles(8, 1'b1, ctl(1, 1, 0, 1, 3));
    check("sat_up_hold", bus.uo_out, 8'hFF);

    // Down by 5 from 3: wrap then saturate.
    cycle(1'b0, 1'b1, ctl(1, 0, 1, 0, 5), 8'h03);
    cycles(4, 1'b1, ctl(1, 0, 0, 0, 5));
    check("down_wrap", bus.uo_out, 8'hFE);
    cycle(1'b0, 1'b1, ctl(1, 0, 1, 1, 5), 8'h03);
    cycles(4, 1'b1, ctl(1, 0, 0, 1, 5));
    check("down_sat", bus.uo_out, 8'h00);
    cycles(8, 1'b1, ctl(1, 0, 0, 1, 5));
    check("down_sat_hold", bus.uo_out, 8'h00);

    // Held load keeps reloading and the phase at zero.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, ctl(1, 1, 1, 0, 1), 8'h05);
    cycles(3, 1'b1, ctl(1, 1, 0, 0, 1));
    check("held_load_phase", bus.uo_out, 8'h05);

    // Mid-count reset clears count and phase.
    cycle(1'b1, 1'b1, ctl(1, 1, 0, 0, 1), 8'h00);
    check("mid_reset", bus.uo_out, 8'h00);
    cycles(3, 1'b1, ctl(1, 1, 0, 0, 1));
    check("post_reset_wait", bus.uo_out, 8'h00);
    cycles(1, 1'b1, ctl(1, 1, 0, 0, 1));
    check("post_reset_tick", bus.uo_out, 8'h01);

    // Enable low freezes everything, step 0 holds, count_en low keeps phase.
    cycles(2, 1'b1, ctl(1, 1, 0, 0, 2));
    cycles(10, 1'b0, ctl(1, 1, 1, 0, 7));
    check("ena_freeze", bus.uo_out, 8'h01);
    cycles(2, 1'b1, ctl(1, 1, 0, 0, 2));
    check("ena_resume", bus.uo_out, 8'h03);
    cycles(12, 1'b1, ctl(1, 1, 0, 0, 0));
    check("step_zero", bus.uo_out, 8'h03);
    cycles(2, 1'b1, ctl(0, 1, 0, 0, 4));
    cycles(2, 1'b1, ctl(1, 1, 0, 0, 4));
    check("cnt_en_phase", bus.uo_out, 8'h07);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit r, e;
      logic [7:0] ui, uio;
      r   = ($urandom_range(0, 63) == 0);
      e   = ($urandom_range(0, 7) != 0);
      ui  = $urandom_range(0, 255);
      ui[2] = ($urandom_range(0, 15) == 0);
      ui[0] = ($urandom_range(0, 3) != 0);
      uio = $urandom_range(0, 255);
      cycle(r, e, ui, uio);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/advanced_counter.md
# advanced_counter

Programmable 8-bit up/down counter core for the `tt_um_advanced_counter` TinyTapeout tile. It has a built-in clock prescaler, a variable step size, parallel load, and selectable wrap or saturate behaviour. The count value is driven directly on the dedicated outputs. The tile wrapper instantiates this block and maps the standard TinyTapeout pins onto it.

## Interface
- One clock; reset is synchronous and active-high.

Parameters:
- `DIV_WIDTH`, default 24: prescaler width. The counter may advance once every 2^DIV_WIDTH clocks. Benches use 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `ena`  in  1  tile enable; 0 freezes all state
- `ui_in`  in  8  controls, one field per bit group:
  - [0] `count_en`
  - [1] `up` (1 = up, 0 = down)
  - [2] `load`
  - [3] `sat` (1 = saturate, 0 = wrap)
  - [7:4] `step`
- `uio_in`  in  8  parallel load value
- `uo_out`  out  8  current count, registered
- `uio_out`  out  8  constant 0
- `uio_oe`  out  8  constant 0; all bidirectional pins are inputs

## Operation
- State consists of the `DIV_WIDTH`-bit prescaler `pre` and the 8-bit `count`.
- `tick` = (`pre` == all ones).
- Per-edge priority, highest first:
  - `rst`: `count` ← 0, `pre` ← 0.
  - `ena`=0: hold everything.
  - `load`=1: `count` ← `uio_in`, `pre` ← 0. Load ignores `tick` and `count_en`.
  - Otherwise `pre` ← `pre`+1, wrapping modulo 2^DIV_WIDTH. If `tick` && `count_en`, `count` ← next.
- Next-value arithmetic is done at 9 bits. `step` is unsigned 0..15; a step of 0 holds the value.
  - up, wrap: (`count`+`step`) mod 256.
  - up, sat: min(`count`+`step`, 255).
  - down, wrap: (`count`−`step`) mod 256.
  - down, sat: max(`count`−`step`, 0).
- The prescaler runs regardless of `count_en`. Deasserting `count_en` does not reset phase.
- `uo_out` = `count` at all times. There are no combinational paths from inputs to `uo_out`.

## Timing
- Reset value: `uo_out`=0x00. `uio_out`/`uio_oe`=0x00 at all times.
- Reset is synchronous: it takes effect on the first rising edge with `rst`=1. Asserting reset mid-count clears both `count` and prescaler phase on that edge.
- After reset release, the first count update lands on edge number 2^DIV_WIDTH, counted from the first edge with `rst`=0. With `DIV_WIDTH`=2 that is the 4th edge. Updates then repeat every 2^DIV_WIDTH edges.
- Load has 1-cycle latency: `uo_out` shows `uio_in` after the edge that samples `load`=1. The next count update comes 2^DIV_WIDTH edges after the last load edge.
- `load` held high for several cycles keeps reloading and keeps the prescaler at 0.
- `sat`, `up` and `step` are sampled on the tick edge only. Changing them between ticks has no effect until the next tick.
- Boundaries:
  - 0xFF up, step 1, wrap → 0x00.
  - 0xFF up, sat → 0xFF.
  - 0x00 down, sat → 0x00.
  - Overshoot (e.g. 0xFE+3 in sat mode) clamps exactly to the limit.

## Structure
- Shared package `advanced_counter_pkg`:
  - field-index localparams for `ui_in` bits (`CNT_EN`, `UP`, `LOAD`, `SAT`, `STEP_LSB`/`STEP_MSB`);
  - `COUNT_W`=8;
  - a `step_t` 4-bit type.
- Sub-module `prescaler`: `DIV_WIDTH` counter with synchronous clear (driven by `rst` or `load`) and a `tick` output.
- Counter datapath and next-value logic live in `advanced_counter`.
- The `tt_um_advanced_counter` wrapper drives `rst` = ~`rst_n` and passes `DIV_WIDTH` through.

## Test plan (DIV_WIDTH=2)
- Reset, then `count_en`=1, up, `step`=1, wrap → `uo_out` reads 0,1,2,3 with one increment every 4 clocks; the first change lands on the 4th edge after reset release.
- Load pulse with `uio_in`=0xFE, then count up with `step`=1, wrap → 0xFE the cycle after load, then 0xFF, then 0x00.
- Load 0xFE, `sat`=1, up, `step`=3 → 0xFF, which stays at 0xFF on subsequent ticks.
- Load 0x03, down, `step`=5:
  - wrap → 0xFE;
  - repeat with `sat`=1 → 0x00, which holds.
- Mid-count (`count`=0x05), assert `rst` for 1 cycle → 0x00 on that edge; the next increment comes 4 edges after release.
- `ena`=0 for 10 cycles while counting → `uo_out` unchanged throughout. With `step`=0 → count never changes. `uio_oe`=0x00 throughout all scenarios.
